// File: rtl/hazard_scoreboard.sv
// Bypass selection, long-latency destination scoreboard and single stall for
// the EX stage, plus a consecutive-stall counter with watchdog.
module hazard_scoreboard #(
    parameter  int NUM_SRC     = 2,
    parameter  int NUM_FWD     = 2,
    parameter  int STALL_LIMIT = 64,
    localparam int SEL_W       = $clog2(NUM_FWD + 2)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [5*NUM_SRC-1:0]     src_addr,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [4:0]               ex_rd,
    input  logic                     ex_rd_valid,
    input  logic [5*NUM_FWD-1:0]     fwd_rd,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [NUM_FWD-1:0]       fwd_ready,
    input  logic                     issue_valid,
    input  logic                     complete_valid,
    input  logic [4:0]               complete_rd,
    output logic [SEL_W*NUM_SRC-1:0] fwd_sel,
    output logic                     stall_o,
    output logic [5:0]               pending_count,
    output logic                     watchdog_o
);

    localparam logic [SEL_W-1:0] SEL_COMPLETE = SEL_W'(NUM_FWD + 1);
    localparam logic [7:0]       LIMIT        = 8'(STALL_LIMIT);

    logic [31:0]        pending_q, pending_d;
    logic [5:0]         count_q, count_d;
    logic [7:0]         stall_cnt_q, stall_cnt_d;
    logic [NUM_SRC-1:0] op_stall;
    logic               waw_stall;
    logic               do_set, do_clr, set_fresh, same_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_operand
            logic [4:0]       addr_c;
            logic [SEL_W-1:0] sel_c;
            logic             stall_c;
            logic             hit_c;

            assign addr_c = src_addr[5*gi +: 5];

            // Descending scan so the youngest matching stage is the last to win.
            always_comb begin
                sel_c   = '0;
                stall_c = 1'b0;
                hit_c   = 1'b0;
                if (src_valid[gi] && addr_c != 5'd0) begin
                    for (int k = NUM_FWD - 1; k >= 0; k--) begin
                        if (fwd_valid[k] && fwd_rd[5*k +: 5] == addr_c) begin
                            hit_c   = 1'b1;
                            sel_c   = SEL_W'(k + 1);
                            stall_c = !fwd_ready[k];
                        end
                    end
                    if (!hit_c) begin
                        if (complete_valid && complete_rd == addr_c) begin
                            sel_c = SEL_COMPLETE;
                        end else if (pending_q[addr_c]) begin
                            stall_c = 1'b1;
                        end
                    end
                end
            end

            assign fwd_sel[gi*SEL_W +: SEL_W] = sel_c;
            assign op_stall[gi]               = stall_c;
        end
    endgenerate

    assign waw_stall = ex_rd_valid && ex_rd != 5'd0 && pending_q[ex_rd]
                       && !(complete_valid && complete_rd == ex_rd);
    assign stall_o   = (|op_stall) || waw_stall;

    // A clear only counts when the bit is actually pending; a set that lands
    // on the register being cleared keeps the bit and nets out to zero.
    assign do_set    = issue_valid && !stall_o && ex_rd != 5'd0;
    assign do_clr    = complete_valid && pending_q[complete_rd];
    assign same_reg  = do_set && do_clr && ex_rd == complete_rd;
    assign set_fresh = do_set && !pending_q[ex_rd];

    always_comb begin
        pending_d = pending_q;
        if (do_clr) pending_d[complete_rd] = 1'b0;
        if (do_set) pending_d[ex_rd] = 1'b1;
    end

    always_comb begin
        count_d = count_q;
        case ({set_fresh, do_clr && !same_reg})
            2'b10:   count_d = count_q + 6'd1;
            2'b01:   count_d = count_q - 6'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        stall_cnt_d = 8'd0;
        if (stall_o) begin
            stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pending_count = count_q;
    assign watchdog_o    = stall_cnt_q >= LIMIT;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of bypass priority, load-use, scoreboard set/clear, WAW,
// x0 handling, watchdog and asynchronous reset of hazard_scoreboard.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic [9:0] src_addr;
    logic [1:0] src_valid;
    logic [4:0] ex_rd;
    logic       ex_rd_valid;
    logic [9:0] fwd_rd;
    logic [1:0] fwd_valid;
    logic [1:0] fwd_ready;
    logic       issue_valid;
    logic       complete_valid;
    logic [4:0] complete_rd;
    logic [3:0] fwd_sel;
    logic       stall_o;
    logic [5:0] pending_count;
    logic       watchdog_o;

    int tests_run;
    int tests_failed;

    hazard_scoreboard #(.NUM_SRC(2), .NUM_FWD(2), .STALL_LIMIT(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_addr       (src_addr),
        .src_valid      (src_valid),
        .ex_rd          (ex_rd),
        .ex_rd_valid    (ex_rd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_valid      (fwd_valid),
        .fwd_ready      (fwd_ready),
        .issue_valid    (issue_valid),
        .complete_valid (complete_valid),
        .complete_rd    (complete_rd),
        .fwd_sel        (fwd_sel),
        .stall_o        (stall_o),
        .pending_count  (pending_count),
        .watchdog_o     (watchdog_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        src_addr       = '0;
        src_valid      = '0;
        ex_rd          = '0;
        ex_rd_valid    = 1'b0;
        fwd_rd         = '0;
        fwd_valid      = '0;
        fwd_ready      = '0;
        issue_valid    = 1'b0;
        complete_valid = 1'b0;
        complete_rd    = '0;
    endtask

    // Inputs change 1 time unit after the rising edge, outputs sampled 1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (fwd_sel !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_fwd_sel: got %b expected %b", fwd_sel, 4'b0000);
        end
        tests_run++;
        if (stall_o !== 1'b0 || watchdog_o !== 1'b0 || pending_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got stall=%b wd=%b cnt=%0d expected 0 0 0",
                     stall_o, watchdog_o, pending_count);
        end
        step();
        rst_n = 1'b1;
        step();
        $display("[TB] reset done");
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        src_addr  = {5'd5, 5'd5};
        src_valid = 2'b01;
        fwd_rd    = {5'd5, 5'd5};
        fwd_valid = 2'b11;
        fwd_ready = 2'b11;
        #1;
        tests_run++;
        if (fwd_sel !== 4'b0001 || stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_youngest: got sel=%b stall=%b expected sel=0001 stall=0",
                     fwd_sel, stall_o);
        end
        fwd_rd = {5'd5, 5'd6};
        #1;
        tests_run++;
        if (fwd_sel !== 4'b0010) begin
            tests_failed++;
            $display("FAIL fwd_older_stage: got %b expected %b", fwd_sel, 4'b0010);
        end
        $display("[TB] forward priority checked");
    endtask

    task automatic test_load_use();
        clear_inputs();
        fwd_rd    = {5'd0, 5'd7};
        fwd_valid = 2'b01;
        fwd_ready = 2'b00;
        src_addr  = {5'd7, 5'd0};
        src_valid = 2'b10;
        #1;
        tests_run++;
        if (stall_o !== 1'b1 || fwd_sel !== 4'b0100) begin
            tests_failed++;
            $display("FAIL load_use_stall: got stall=%b sel=%b expected stall=1 sel=0100",
                     stall_o, fwd_sel);
        end
        fwd_ready = 2'b01;
        #1;
        tests_run++;
        if (stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_use_ready: got %b expected %b", stall_o, 1'b0);
        end
        step();
        $display("[TB] load-use checked");
    endtask

    task automatic test_long_op();
        clear_inputs();
        ex_rd       = 5'd9;
        ex_rd_valid = 1'b1;
        issue_valid = 1'b1;
        #1;
        tests_run++;
        if (stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_issue_nostall: got %b expected %b", stall_o, 1'b0);
        end
        step();
        clear_inputs();
        src_addr  = {5'd0, 5'd9};
        src_valid = 2'b01;
        #1;
        tests_run++;
        if (stall_o !== 1'b1 || pending_count !== 6'd1 || fwd_sel !== 4'b0000) begin
            tests_failed++;
            $display("FAIL long_consumer: got stall=%b cnt=%0d sel=%b expected 1 1 0000",
                     stall_o, pending_count, fwd_sel);
        end
        step();
        complete_valid = 1'b1;
        complete_rd    = 5'd9;
        #1;
        tests_run++;
        if (fwd_sel !== 4'b0011 || stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_complete_bypass: got sel=%b stall=%b expected 0011 0",
                     fwd_sel, stall_o);
        end
        step();
        complete_valid = 1'b0;
        #1;
        tests_run++;
        if (pending_count !== 6'd0 || stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_cleared: got cnt=%0d stall=%b expected 0 0",
                     pending_count, stall_o);
        end
        $display("[TB] long op checked");
    endtask

    task automatic test_waw();
        clear_inputs();
        ex_rd       = 5'd9;
        ex_rd_valid = 1'b1;
        issue_valid = 1'b1;
        step();
        #1;
        tests_run++;
        if (stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL waw_stall: got %b expected %b", stall_o, 1'b1);
        end
        step();
        tests_run++;
        if (pending_count !== 6'd1) begin
            tests_failed++;
            $display("FAIL waw_issue_ignored: got %0d expected %0d", pending_count, 1);
        end
        ex_rd          = 5'd4;
        complete_valid = 1'b1;
        complete_rd    = 5'd9;
        step();
        clear_inputs();
        src_addr  = {5'd9, 5'd4};
        src_valid = 2'b01;
        #1;
        tests_run++;
        if (pending_count !== 6'd1 || stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL swap_x4_pending: got cnt=%0d stall=%b expected 1 1",
                     pending_count, stall_o);
        end
        src_valid = 2'b10;
        #1;
        tests_run++;
        if (stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL swap_x9_cleared: got %b expected %b", stall_o, 1'b0);
        end
        // Re-issue to x4 while x4 completes: set wins, count unchanged.
        clear_inputs();
        ex_rd          = 5'd4;
        ex_rd_valid    = 1'b1;
        issue_valid    = 1'b1;
        complete_valid = 1'b1;
        complete_rd    = 5'd4;
        #1;
        tests_run++;
        if (stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_reg_nostall: got %b expected %b", stall_o, 1'b0);
        end
        step();
        clear_inputs();
        src_addr  = {5'd0, 5'd4};
        src_valid = 2'b01;
        #1;
        tests_run++;
        if (pending_count !== 6'd1 || stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_reg_set_wins: got cnt=%0d stall=%b expected 1 1",
                     pending_count, stall_o);
        end
        clear_inputs();
        complete_valid = 1'b1;
        complete_rd    = 5'd4;
        step();
        complete_rd = 5'd12;
        step();
        complete_valid = 1'b0;
        tests_run++;
        if (pending_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL spurious_complete: got %0d expected %0d", pending_count, 0);
        end
        $display("[TB] waw and scoreboard update checked");
    endtask

    task automatic test_x0();
        clear_inputs();
        src_addr    = 10'd0;
        src_valid   = 2'b11;
        fwd_rd      = 10'd0;
        fwd_valid   = 2'b01;
        fwd_ready   = 2'b00;
        ex_rd       = 5'd0;
        ex_rd_valid = 1'b1;
        issue_valid = 1'b1;
        #1;
        tests_run++;
        if (fwd_sel !== 4'b0000 || stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_no_bypass: got sel=%b stall=%b expected 0000 0", fwd_sel, stall_o);
        end
        step();
        tests_run++;
        if (pending_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL x0_never_pending: got %0d expected %0d", pending_count, 0);
        end
        clear_inputs();
        step();
        $display("[TB] x0 checked");
    endtask

    task automatic test_watchdog();
        clear_inputs();
        fwd_rd    = {5'd0, 5'd7};
        fwd_valid = 2'b01;
        src_addr  = {5'd0, 5'd7};
        src_valid = 2'b01;
        for (int i = 0; i < 63; i++) step();
        tests_run++;
        if (watchdog_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL watchdog_63: got %b expected %b", watchdog_o, 1'b0);
        end
        step();
        tests_run++;
        if (watchdog_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL watchdog_64: got %b expected %b", watchdog_o, 1'b1);
        end
        fwd_ready = 2'b01;
        #1;
        tests_run++;
        if (watchdog_o !== 1'b1 || stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL watchdog_hold: got wd=%b stall=%b expected 1 0", watchdog_o, stall_o);
        end
        step();
        tests_run++;
        if (watchdog_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL watchdog_drop: got %b expected %b", watchdog_o, 1'b0);
        end
        $display("[TB] watchdog checked");
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        ex_rd       = 5'd3;
        ex_rd_valid = 1'b1;
        issue_valid = 1'b1;
        step();
        clear_inputs();
        fwd_rd    = {5'd0, 5'd7};
        fwd_valid = 2'b01;
        src_addr  = {5'd0, 5'd7};
        src_valid = 2'b01;
        for (int i = 0; i < 70; i++) step();
        tests_run++;
        if (watchdog_o !== 1'b1 || pending_count !== 6'd1) begin
            tests_failed++;
            $display("FAIL pre_reset_state: got wd=%b cnt=%0d expected 1 1", watchdog_o, pending_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (watchdog_o !== 1'b0 || pending_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL async_reset_clear: got wd=%b cnt=%0d expected 0 0", watchdog_o, pending_count);
        end
        clear_inputs();
        src_addr  = {5'd0, 5'd3};
        src_valid = 2'b01;
        #1;
        tests_run++;
        if (stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_discard_pending: got %b expected %b", stall_o, 1'b0);
        end
        step();
        rst_n          = 1'b1;
        complete_valid = 1'b1;
        complete_rd    = 5'd3;
        step();
        complete_valid = 1'b0;
        tests_run++;
        if (pending_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL stale_complete: got %0d expected %0d", pending_count, 0);
        end
        $display("[TB] mid-operation reset checked");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_long_op();
        test_waw();
        test_x0();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
